// File: rtl/axi4_lite_pkg.sv
// ============================================================================
// Module      : axi4_lite_pkg
// Description : Shared AXI4-Lite types and response codes for the master
//               engine and the slave BFM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_RSP          = 3'd5
    } axi_mst_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Reported on rsp_resp when the watchdog abandons a transaction.
    localparam logic [1:0] AXI_RESP_TIMEOUT = 2'b11;

endpackage

`default_nettype wire

// File: rtl/axi4_lite_master_engine.sv
// ============================================================================
// Module      : axi4_lite_master_engine
// Description : Single-outstanding AXI4-Lite master turning cmd_* requests
//               into bus transactions and returning rsp_* completions.
//               Optional watchdog enabled by AXI4L_MST_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_lite_master_engine
    import axi4_lite_pkg::*;
#(
    parameter logic [2:0]  AXPROT         = 3'b000,
    parameter logic [3:0]  AXCACHE        = 4'b0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    // command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    // response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        timeout_err,
    // AXI4-Lite master
    output logic [31:0] m_awaddr,
    output logic [3:0]  m_awcache,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arcache,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    axi_mst_state_e r_state, w_state_next;

    logic        r_cmd_ready, w_cmd_ready_next;
    logic [31:0] r_awaddr,    w_awaddr_next;
    logic        r_awvalid,   w_awvalid_next;
    logic [31:0] r_wdata,     w_wdata_next;
    logic [3:0]  r_wstrb,     w_wstrb_next;
    logic        r_wvalid,    w_wvalid_next;
    logic        r_bready,    w_bready_next;
    logic [31:0] r_araddr,    w_araddr_next;
    logic        r_arvalid,   w_arvalid_next;
    logic        r_rready,    w_rready_next;
    logic        r_rsp_valid, w_rsp_valid_next;
    logic        r_rsp_write, w_rsp_write_next;
    logic [31:0] r_rsp_rdata, w_rsp_rdata_next;
    logic [1:0]  r_rsp_resp,  w_rsp_resp_next;
    logic        r_aw_done,   w_aw_done_next;
    logic        r_w_done,    w_w_done_next;

    logic w_aw_hs, w_w_hs;

    assign w_aw_hs = r_awvalid & m_awready;
    assign w_w_hs  = r_wvalid  & m_wready;

`ifdef AXI4L_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_next;
    logic             r_timeout_err, w_timeout_err_next;
    logic             w_in_wait;

    assign w_in_wait = (r_state == ST_WR_ADDR_DATA) || (r_state == ST_WR_RESP) ||
                       (r_state == ST_RD_ADDR)      || (r_state == ST_RD_DATA);
`endif

    always_comb begin
        w_state_next     = r_state;
        w_cmd_ready_next = r_cmd_ready;
        w_awaddr_next    = r_awaddr;
        w_awvalid_next   = r_awvalid;
        w_wdata_next     = r_wdata;
        w_wstrb_next     = r_wstrb;
        w_wvalid_next    = r_wvalid;
        w_bready_next    = r_bready;
        w_araddr_next    = r_araddr;
        w_arvalid_next   = r_arvalid;
        w_rready_next    = r_rready;
        w_rsp_valid_next = r_rsp_valid;
        w_rsp_write_next = r_rsp_write;
        w_rsp_rdata_next = r_rsp_rdata;
        w_rsp_resp_next  = r_rsp_resp;
        w_aw_done_next   = r_aw_done;
        w_w_done_next    = r_w_done;

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready_next = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_next = 1'b0;
                    if (cmd_write) begin
                        w_awaddr_next  = cmd_addr;
                        w_wdata_next   = cmd_wdata;
                        w_wstrb_next   = cmd_wstrb;
                        w_awvalid_next = 1'b1;
                        w_wvalid_next  = 1'b1;
                        w_state_next   = ST_WR_ADDR_DATA;
                    end else begin
                        w_araddr_next  = cmd_addr;
                        w_arvalid_next = 1'b1;
                        w_state_next   = ST_RD_ADDR;
                    end
                end
            end
            ST_WR_ADDR_DATA: begin
                // AW and W complete independently, possibly in the same cycle.
                if (w_aw_hs) begin
                    w_awvalid_next = 1'b0;
                    w_aw_done_next = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_next = 1'b0;
                    w_w_done_next = 1'b1;
                end
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_aw_done_next = 1'b0;
                    w_w_done_next  = 1'b0;
                    w_bready_next  = 1'b1;
                    w_state_next   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_bvalid && r_bready) begin
                    w_bready_next    = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_write_next = 1'b1;
                    w_rsp_rdata_next = 32'd0;
                    w_rsp_resp_next  = m_bresp;
                    w_state_next     = ST_RSP;
                end
            end
            ST_RD_ADDR: begin
                if (r_arvalid && m_arready) begin
                    w_arvalid_next = 1'b0;
                    w_rready_next  = 1'b1;
                    w_state_next   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_rvalid && r_rready) begin
                    w_rready_next    = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_write_next = 1'b0;
                    w_rsp_rdata_next = m_rdata;
                    w_rsp_resp_next  = m_rresp;
                    w_state_next     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_next = 1'b0;
                    w_cmd_ready_next = 1'b1;
                    w_state_next     = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

`ifdef AXI4L_MST_TIMEOUT_EN
        // Counter restarts whenever the state changes; a handshake completing
        // on the expiry cycle takes priority over the watchdog.
        w_wait_cnt_next    = '0;
        w_timeout_err_next = r_timeout_err;
        if (w_in_wait && (w_state_next == r_state)) begin
            if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                w_awvalid_next     = 1'b0;
                w_wvalid_next      = 1'b0;
                w_bready_next      = 1'b0;
                w_arvalid_next     = 1'b0;
                w_rready_next      = 1'b0;
                w_aw_done_next     = 1'b0;
                w_w_done_next      = 1'b0;
                w_rsp_valid_next   = 1'b1;
                w_rsp_write_next   = (r_state == ST_WR_ADDR_DATA) || (r_state == ST_WR_RESP);
                w_rsp_rdata_next   = 32'd0;
                w_rsp_resp_next    = AXI_RESP_TIMEOUT;
                w_timeout_err_next = 1'b1;
                w_state_next       = ST_RSP;
            end else begin
                w_wait_cnt_next = r_wait_cnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_awaddr    <= 32'd0;
            r_awvalid   <= 1'b0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= 32'd0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_resp  <= 2'd0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= w_cmd_ready_next;
            r_awaddr    <= w_awaddr_next;
            r_awvalid   <= w_awvalid_next;
            r_wdata     <= w_wdata_next;
            r_wstrb     <= w_wstrb_next;
            r_wvalid    <= w_wvalid_next;
            r_bready    <= w_bready_next;
            r_araddr    <= w_araddr_next;
            r_arvalid   <= w_arvalid_next;
            r_rready    <= w_rready_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_write <= w_rsp_write_next;
            r_rsp_rdata <= w_rsp_rdata_next;
            r_rsp_resp  <= w_rsp_resp_next;
            r_aw_done   <= w_aw_done_next;
            r_w_done    <= w_w_done_next;
        end
    end

`ifdef AXI4L_MST_TIMEOUT_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wait_cnt    <= w_wait_cnt_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;

    assign m_awaddr  = r_awaddr;
    assign m_awcache = AXCACHE;
    assign m_awprot  = AXPROT;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;
    assign m_araddr  = r_araddr;
    assign m_arcache = AXCACHE;
    assign m_arprot  = AXPROT;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_master_engine.sv
// ============================================================================
// Module      : tb_axi4_lite_master_engine
// Description : Directed bench for axi4_lite_master_engine with a simple
//               AXI4-Lite slave model (watchdog test under AXI4L_MST_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi4_lite_master_engine;
    import axi4_lite_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout_err;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_awcache, m_arcache, m_wstrb;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    always #5 aclk = ~aclk;

    axi4_lite_master_engine #(
        .AXPROT        (3'b000),
        .AXCACHE       (4'b0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_wstrb  (cmd_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_write  (rsp_write),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .timeout_err(timeout_err),
        .m_awaddr   (m_awaddr),
        .m_awcache  (m_awcache),
        .m_awprot   (m_awprot),
        .m_awvalid  (m_awvalid),
        .m_awready  (m_awready),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_wvalid   (m_wvalid),
        .m_wready   (m_wready),
        .m_bresp    (m_bresp),
        .m_bvalid   (m_bvalid),
        .m_bready   (m_bready),
        .m_araddr   (m_araddr),
        .m_arcache  (m_arcache),
        .m_arprot   (m_arprot),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_rdata    (m_rdata),
        .m_rresp    (m_rresp),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- slave model (drives on the falling edge) ----------------
    int          aw_wait = 0, w_wait = 0;
    bit          ar_never = 0, b_never = 0;
    logic [1:0]  b_resp_cfg = AXI_RESP_OKAY, r_resp_cfg = AXI_RESP_OKAY;
    bit          aw_got, w_got, ar_got, b_fire, r_fire;
    int          aw_cnt, w_cnt;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [31:0] mem [logic [31:0]];

    initial begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0; aw_cnt = 0; w_cnt = 0;
        s_awaddr = 0; s_wdata = 0; s_araddr = 0; s_wstrb = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0; aw_cnt = 0; w_cnt = 0;
            end else begin
                if (m_awvalid && !aw_got) begin
                    if (aw_cnt >= aw_wait) begin m_awready = 1; aw_got = 1; s_awaddr = m_awaddr; end
                    else begin m_awready = 0; aw_cnt++; end
                end else m_awready = 0;
                if (m_wvalid && !w_got) begin
                    if (w_cnt >= w_wait) begin m_wready = 1; w_got = 1; s_wdata = m_wdata; s_wstrb = m_wstrb; end
                    else begin m_wready = 0; w_cnt++; end
                end else m_wready = 0;
                if (m_bvalid) begin
                    if (b_fire) begin
                        m_bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
                    end else if (m_bready) b_fire = 1;
                end else if (aw_got && w_got && !m_awready && !m_wready && !b_never) begin
                    logic [31:0] old;
                    old = mem.exists(s_awaddr) ? mem[s_awaddr] : 32'd0;
                    for (int i = 0; i < 4; i++)
                        if (s_wstrb[i]) old[i*8 +: 8] = s_wdata[i*8 +: 8];
                    mem[s_awaddr] = old;
                    m_bvalid = 1; m_bresp = b_resp_cfg;
                    if (m_bready) b_fire = 1;
                end
                if (m_arvalid && !ar_got && !ar_never) begin
                    m_arready = 1; ar_got = 1; s_araddr = m_araddr;
                end else m_arready = 0;
                if (m_rvalid) begin
                    if (r_fire) begin m_rvalid = 0; r_fire = 0; ar_got = 0; end
                    else if (m_rready) r_fire = 1;
                end else if (ar_got && !m_arready) begin
                    m_rvalid = 1; m_rresp = r_resp_cfg;
                    m_rdata = mem.exists(s_araddr) ? mem[s_araddr] : 32'd0;
                    if (m_rready) r_fire = 1;
                end
            end
        end
    end

    // Offer one command; returns at 1 ns after the accepting edge.
    task automatic send_cmd(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge aclk);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
        @(posedge aclk); #1;
        cmd_valid = 0;
        check_eq("cmd_accepted", 64'(n < 50), 64'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 100) begin @(posedge aclk); #1; n++; end
        check_eq(tag, 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          aw_first, early_b, stable, cr_low;
        int          rsp_cnt, arv_cnt;
        logic [1:0]  s_resp;
        logic        s_wr;
        logic [31:0] s_rd;

        aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 1;
        repeat (3) @(posedge aclk);
        #1;
        check_eq("rst_cmd_ready", 64'(cmd_ready), 0);
        check_eq("rst_awvalid",   64'(m_awvalid), 0);
        check_eq("rst_wvalid",    64'(m_wvalid), 0);
        check_eq("rst_arvalid",   64'(m_arvalid), 0);
        check_eq("rst_bready",    64'(m_bready), 0);
        check_eq("rst_rready",    64'(m_rready), 0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 0);
        check_eq("rst_timeout",   64'(timeout_err), 0);
        check_eq("rst_awaddr",    64'(m_awaddr), 0);
        check_eq("rst_araddr",    64'(m_araddr), 0);
        check_eq("rst_rsp_rdata", 64'(rsp_rdata), 0);
        aresetn = 1;
        @(posedge aclk); #1;
        check_eq("rel_cmd_ready", 64'(cmd_ready), 1);

        // 1: zero-wait write, cycle-exact
        send_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF);
        check_eq("t1_cmd_ready_drop", 64'(cmd_ready), 0);
        check_eq("t1_awvalid", 64'(m_awvalid), 1);
        check_eq("t1_wvalid",  64'(m_wvalid), 1);
        check_eq("t1_awaddr",  64'(m_awaddr), 64'h10);
        check_eq("t1_wdata",   64'(m_wdata), 64'hDEADBEEF);
        check_eq("t1_wstrb",   64'(m_wstrb), 64'hF);
        check_eq("t1_awprot",  64'(m_awprot), 0);
        @(posedge aclk); #1;
        check_eq("t1_awvalid_fall", 64'(m_awvalid), 0);
        check_eq("t1_wvalid_fall",  64'(m_wvalid), 0);
        check_eq("t1_bready",       64'(m_bready), 1);
        @(posedge aclk); #1;
        check_eq("t1_rsp_valid", 64'(rsp_valid), 1);
        check_eq("t1_rsp_write", 64'(rsp_write), 1);
        check_eq("t1_rsp_resp",  64'(rsp_resp), 0);
        check_eq("t1_rsp_rdata", 64'(rsp_rdata), 0);
        check_eq("t1_bready_fall", 64'(m_bready), 0);
        @(posedge aclk); #1;
        check_eq("t1_rsp_done",  64'(rsp_valid), 0);
        check_eq("t1_cmd_ready", 64'(cmd_ready), 1);

        // 2: read back, cycle-exact
        send_cmd(0, 32'h10, 32'h0, 4'h0);
        check_eq("t2_arvalid", 64'(m_arvalid), 1);
        check_eq("t2_araddr",  64'(m_araddr), 64'h10);
        @(posedge aclk); #1;
        check_eq("t2_arvalid_fall", 64'(m_arvalid), 0);
        check_eq("t2_rready",       64'(m_rready), 1);
        @(posedge aclk); #1;
        check_eq("t2_rsp_valid", 64'(rsp_valid), 1);
        check_eq("t2_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        check_eq("t2_rsp_resp",  64'(rsp_resp), 0);
        check_eq("t2_rsp_write", 64'(rsp_write), 0);
        @(posedge aclk); #1;
        check_eq("t2_cmd_ready", 64'(cmd_ready), 1);

        // 3: wready lags awready by 3 cycles
        w_wait = 3;
        send_cmd(1, 32'h20, 32'h12345678, 4'hF);
        aw_first = 0; early_b = 0; rsp_cnt = 0; s_resp = 2'b01; s_wr = 0;
        for (int i = 0; i < 30; i++) begin
            if (!m_awvalid && m_wvalid) aw_first = 1;
            if (m_bready && (m_awvalid || m_wvalid)) early_b = 1;
            if (rsp_valid) begin rsp_cnt++; s_resp = rsp_resp; s_wr = rsp_write; end
            @(posedge aclk); #1;
        end
        w_wait = 0;
        check_eq("t3_aw_first",  64'(aw_first), 1);
        check_eq("t3_early_b",   64'(early_b), 0);
        check_eq("t3_rsp_count", 64'(rsp_cnt), 1);
        check_eq("t3_rsp_resp",  64'(s_resp), 0);
        check_eq("t3_rsp_write", 64'(s_wr), 1);

        // 4: SLVERR read with back-pressured response
        r_resp_cfg = AXI_RESP_SLVERR;
        rsp_ready  = 0;
        send_cmd(0, 32'h100, 32'h0, 4'h0);
        wait_rsp("t4_rsp_seen");
        s_resp = rsp_resp; s_wr = rsp_write; s_rd = rsp_rdata;
        stable = 1; cr_low = 1;
        repeat (5) begin
            @(posedge aclk); #1;
            if (!rsp_valid || rsp_resp != s_resp || rsp_write != s_wr || rsp_rdata != s_rd) stable = 0;
            if (cmd_ready) cr_low = 0;
        end
        check_eq("t4_rsp_resp",  64'(s_resp), 64'(AXI_RESP_SLVERR));
        check_eq("t4_rsp_write", 64'(s_wr), 0);
        check_eq("t4_stable",    64'(stable), 1);
        check_eq("t4_cmd_ready_low", 64'(cr_low), 1);
        rsp_ready = 1;
        @(posedge aclk); #1;
        check_eq("t4_rsp_drop", 64'(rsp_valid), 0);
        @(posedge aclk); #1;
        check_eq("t4_cmd_ready", 64'(cmd_ready), 1);
        r_resp_cfg = AXI_RESP_OKAY;

        // 5: reset while waiting for B
        b_never = 1;
        send_cmd(1, 32'h30, 32'hA5A5A5A5, 4'h3);
        for (int i = 0; i < 20 && !m_bready; i++) begin @(posedge aclk); #1; end
        check_eq("t5_in_wr_resp", 64'(m_bready), 1);
        aresetn = 0;
        @(posedge aclk); #1;
        check_eq("t5_awvalid",   64'(m_awvalid), 0);
        check_eq("t5_wvalid",    64'(m_wvalid), 0);
        check_eq("t5_bready",    64'(m_bready), 0);
        check_eq("t5_rsp_valid", 64'(rsp_valid), 0);
        check_eq("t5_cmd_ready", 64'(cmd_ready), 0);
        check_eq("t5_awaddr",    64'(m_awaddr), 0);
        aresetn = 1;
        b_never = 0;
        @(posedge aclk); #1;
        check_eq("t5_rel_cmd_ready", 64'(cmd_ready), 1);
        send_cmd(1, 32'h30, 32'h11223344, 4'hF);
        wait_rsp("t5_new_rsp");
        check_eq("t5_new_resp",  64'(rsp_resp), 0);
        check_eq("t5_new_write", 64'(rsp_write), 1);
        send_cmd(0, 32'h30, 32'h0, 4'h0);
        wait_rsp("t5_rd_rsp");
        check_eq("t5_rd_data", 64'(rsp_rdata), 64'h11223344);

`ifdef AXI4L_MST_TIMEOUT_EN
        // 6: slave never accepts AR
        ar_never = 1;
        send_cmd(0, 32'h40, 32'h0, 4'h0);
        arv_cnt = 0;
        while (m_arvalid && arv_cnt < 100) begin arv_cnt++; @(posedge aclk); #1; end
        check_eq("t6_arvalid_cycles", 64'(arv_cnt), 16);
        check_eq("t6_rsp_valid",  64'(rsp_valid), 1);
        check_eq("t6_rsp_resp",   64'(rsp_resp), 64'(AXI_RESP_TIMEOUT));
        check_eq("t6_rsp_rdata",  64'(rsp_rdata), 0);
        check_eq("t6_timeout",    64'(timeout_err), 1);
        @(posedge aclk); #1;
        check_eq("t6_sticky",     64'(timeout_err), 1);
        check_eq("t6_rready",     64'(m_rready), 0);
        ar_never = 0;
`else
        check_eq("no_timeout_err", 64'(timeout_err), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
